// File: rtl/audio_dac_serializer_if.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer_if
// Write-side handshake between audio sample producers and the I2S DAC
// serializer.
//   wr_valid  : producer presents a stereo pair this cycle
//   wr_left   : signed left sample
//   wr_right  : signed right sample
//   ready     : FIFO has space; a pair is taken when wr_valid & ready
//   fill      : current FIFO occupancy in pairs
// master = producer side, slave = serializer side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface audio_dac_serializer_if #(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 8
);
    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

    logic                wr_valid;
    logic [SAMPLE_W-1:0] wr_left;
    logic [SAMPLE_W-1:0] wr_right;
    logic                ready;
    logic [FILL_W-1:0]   fill;

    modport master (
        output wr_valid,
        output wr_left,
        output wr_right,
        input  ready,
        input  fill
    );

    modport slave (
        input  wr_valid,
        input  wr_left,
        input  wr_right,
        output ready,
        output fill
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
// Buffers signed stereo sample pairs in a small FIFO and shifts them out to
// the board DAC as I2S (64 BCLK periods per frame, 32 per channel, data one
// BCLK after the word-select edge, MSB first).
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   wr            : slave side of the sample write handshake (see _if)
//   clr_underrun  : clears the sticky underrun flag
//   underrun      : sticky, a frame started while the FIFO was empty
//   aud_bclk      : bit clock, BCLK_HALF clk cycles per half period
//   aud_daclrck   : word select, 0 = left, 1 = right
//   aud_dacdat    : serial data, changes on BCLK falling edges
// SAMPLE_W must be 2..31 so that every sample fits in a 32-slot half frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module audio_dac_serializer #(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_HALF  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_dac_serializer_if.slave wr,
    input  logic                  clr_underrun,
    output logic                  underrun,
    output logic                  aud_bclk,
    output logic                  aud_daclrck,
    output logic                  aud_dacdat
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FILL_W = AW + 1;
    localparam int DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_HALF - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);
    localparam logic [5:0]        SLOT_LAST = 6'(SAMPLE_W);

    // clock divider / bit position
    logic [DIV_W-1:0]    r_div;
    logic                r_bclk;
    logic [5:0]          r_bit_cnt;
    logic                r_lrck;
    logic                r_dat;
    logic [SAMPLE_W-1:0] r_sh_l;
    logic [SAMPLE_W-1:0] r_sh_r;

    // FIFO
    logic [SAMPLE_W-1:0] r_mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] r_mem_r [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [FILL_W-1:0]   r_fill;
    logic                r_ready;
    logic                r_underrun;

    logic                w_fall;
    logic                w_wrap;
    logic [5:0]          w_cnt_next;
    logic                w_in_slot;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [FILL_W-1:0]   w_fill_next;

    // The fall event is the last divider cycle of a BCLK high phase.
    assign w_fall     = r_bclk & (r_div == DIV_LAST);
    assign w_cnt_next = r_bit_cnt + 6'd1;
    assign w_wrap     = w_fall & (r_bit_cnt == 6'd63);
    // Slot 0 is the I2S one-bit delay; data occupies slots 1..SAMPLE_W.
    assign w_in_slot  = ({1'b0, w_cnt_next[4:0]} >= 6'd1) &&
                        ({1'b0, w_cnt_next[4:0]} <= SLOT_LAST);

    assign w_empty = (r_fill == {FILL_W{1'b0}});
    assign w_push  = wr.wr_valid & r_ready;
    // An empty FIFO at a frame wrap loads silence instead of popping.
    assign w_pop   = w_wrap & ~w_empty;

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        w_fill_next = r_fill;
        case ({w_push, w_pop})
            2'b10:   w_fill_next = r_fill + FILL_W'(1);
            2'b01:   w_fill_next = r_fill - FILL_W'(1);
            default: w_fill_next = r_fill;
        endcase
    end

    // BCLK divider: toggle BCLK every BCLK_HALF clk cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= {DIV_W{1'b0}};
            r_bclk <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div  <= {DIV_W{1'b0}};
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // Bit counter, word select and data shifter, all stepped on fall events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= 6'd0;
            r_lrck    <= 1'b0;
            r_dat     <= 1'b0;
            r_sh_l    <= {SAMPLE_W{1'b0}};
            r_sh_r    <= {SAMPLE_W{1'b0}};
        end else if (w_fall) begin
            r_bit_cnt <= w_cnt_next;
            r_lrck    <= w_cnt_next[5];
            if (w_wrap) begin
                r_dat <= 1'b0;
                if (w_pop) begin
                    r_sh_l <= r_mem_l[r_rptr];
                    r_sh_r <= r_mem_r[r_rptr];
                end else begin
                    r_sh_l <= {SAMPLE_W{1'b0}};
                    r_sh_r <= {SAMPLE_W{1'b0}};
                end
            end else if (w_in_slot) begin
                if (w_cnt_next[5]) begin
                    r_dat  <= r_sh_r[SAMPLE_W-1];
                    r_sh_r <= {r_sh_r[SAMPLE_W-2:0], 1'b0};
                end else begin
                    r_dat  <= r_sh_l[SAMPLE_W-1];
                    r_sh_l <= {r_sh_l[SAMPLE_W-2:0], 1'b0};
                end
            end else begin
                r_dat <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate access.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_l[r_wptr] <= wr.wr_left;
            r_mem_r[r_wptr] <= wr.wr_right;
        end
    end

    // FIFO pointers, occupancy and registered write-space flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_fill  <= {FILL_W{1'b0}};
            r_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_fill  <= w_fill_next;
            r_ready <= (w_fill_next < FILL_FULL);
        end
    end

    // Sticky underrun; a new underrun outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (w_wrap & w_empty) begin
            r_underrun <= 1'b1;
        end else if (clr_underrun) begin
            r_underrun <= 1'b0;
        end
    end

    assign wr.ready    = r_ready;
    assign wr.fill     = r_fill;
    assign underrun    = r_underrun;
    assign aud_bclk    = r_bclk;
    assign aud_daclrck = r_lrck;
    assign aud_dacdat  = r_dat;

endmodule
